// File: rtl/i2c_request_arbiter.sv
// i2c_request_arbiter: round-robin arbiter sharing one I2C master port among N_REQ requesters
module i2c_request_arbiter #(
    parameter int N_REQ          = 4,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int GAP_CYCLES     = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [8*N_REQ-1:0]   req_addr,
    input  logic [N_REQ-1:0]     req_wren,
    input  logic [N_REQ-1:0]     req_rden,
    input  logic [8*N_REQ-1:0]   req_wdata,
    output logic [N_REQ-1:0]     req_ack,
    output logic [N_REQ-1:0]     rsp_valid,
    output logic [7:0]           rsp_rdata,
    output logic                 rsp_error,
    output logic                 rsp_timeout,
    output logic                 m_ce,
    output logic [7:0]           m_addr,
    output logic                 m_wren,
    output logic                 m_rden,
    output logic [7:0]           m_wdata,
    input  logic [7:0]           m_rdata,
    input  logic                 m_ready,
    input  logic                 m_error,
    output logic                 busy,
    output logic [2:0]           grant_id
);
    localparam int PW = $clog2(N_REQ);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int GW = $clog2(GAP_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, BUSY, GAP} state_t;

    state_t             state, state_n;
    logic [PW-1:0]      ptr, ptr_n, off, sel;
    logic [PW:0]        sum;
    logic [N_REQ-1:0]   rot;
    logic [TW-1:0]      tcnt, tcnt_n;
    logic [GW-1:0]      gcnt, gcnt_n;
    logic [7:0]         addr_sel, wdata_sel;
    logic               legal, timeout_hit;
    logic [N_REQ-1:0]   req_ack_n, rsp_valid_n;
    logic [7:0]         rsp_rdata_n, m_addr_n, m_wdata_n;
    logic               rsp_error_n, rsp_timeout_n, m_ce_n, m_wren_n, m_rden_n;
    logic [2:0]         grant_id_n;

    // rotate requests so the pointer sits at bit 0, take the lowest set bit, rotate back
    always_comb begin
        rot = N_REQ'({req_valid, req_valid} >> ptr);
        off = '0;
        for (int k = N_REQ - 1; k >= 0; k--)
            if (rot[k]) off = PW'(k);
        sum = {1'b0, ptr} + {1'b0, off};
        sel = PW'(sum >= (PW+1)'(N_REQ) ? sum - (PW+1)'(N_REQ) : sum);
        addr_sel = 8'(req_addr >> {sel, 3'b000});
        wdata_sel = 8'(req_wdata >> {sel, 3'b000});
        legal = req_wren[sel] ^ req_rden[sel];
        timeout_hit = tcnt == TW'(TIMEOUT_CYCLES - 1);
    end

    // next state and next registered outputs; responses default to quiet
    always_comb begin
        state_n = state;
        ptr_n = ptr;
        tcnt_n = tcnt;
        gcnt_n = gcnt;
        req_ack_n = '0;
        rsp_valid_n = '0;
        rsp_rdata_n = '0;
        rsp_error_n = 1'b0;
        rsp_timeout_n = 1'b0;
        m_ce_n = m_ce;
        m_addr_n = m_addr;
        m_wren_n = m_wren;
        m_rden_n = m_rden;
        m_wdata_n = m_wdata;
        grant_id_n = grant_id;
        case (state)
            IDLE: if (|req_valid) begin
                req_ack_n = N_REQ'(1) << sel;
                ptr_n = (sel == PW'(N_REQ - 1)) ? '0 : sel + PW'(1);
                if (legal) begin
                    state_n = BUSY;
                    tcnt_n = '0;
                    m_ce_n = 1'b1;
                    m_addr_n = addr_sel;
                    m_wren_n = req_wren[sel];
                    m_rden_n = req_rden[sel];
                    m_wdata_n = req_wren[sel] ? wdata_sel : 8'h00;
                    grant_id_n = 3'(sel);
                end else begin
                    rsp_valid_n = N_REQ'(1) << sel;
                    rsp_error_n = 1'b1;
                end
            end
            BUSY: begin
                tcnt_n = tcnt + TW'(1);
                if (m_error || m_ready || timeout_hit) begin
                    state_n = GAP;
                    gcnt_n = '0;
                    m_ce_n = 1'b0;
                    m_addr_n = '0;
                    m_wren_n = 1'b0;
                    m_rden_n = 1'b0;
                    m_wdata_n = '0;
                    rsp_valid_n = N_REQ'(1) << grant_id;
                    rsp_error_n = m_error || !m_ready;
                    rsp_timeout_n = !m_error && !m_ready;
                    rsp_rdata_n = (!m_error && m_ready && m_rden) ? m_rdata : 8'h00;
                end
            end
            GAP: begin
                if (gcnt == GW'(GAP_CYCLES - 2)) state_n = IDLE;
                else gcnt_n = gcnt + GW'(1);
            end
            default: state_n = IDLE;
        endcase
    end

    // state, counters and every output are registered; reset aborts silently
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            ptr <= '0;
            tcnt <= '0;
            gcnt <= '0;
            req_ack <= '0;
            rsp_valid <= '0;
            rsp_rdata <= '0;
            rsp_error <= 1'b0;
            rsp_timeout <= 1'b0;
            m_ce <= 1'b0;
            m_addr <= '0;
            m_wren <= 1'b0;
            m_rden <= 1'b0;
            m_wdata <= '0;
            busy <= 1'b0;
            grant_id <= '0;
        end else begin
            state <= state_n;
            ptr <= ptr_n;
            tcnt <= tcnt_n;
            gcnt <= gcnt_n;
            req_ack <= req_ack_n;
            rsp_valid <= rsp_valid_n;
            rsp_rdata <= rsp_rdata_n;
            rsp_error <= rsp_error_n;
            rsp_timeout <= rsp_timeout_n;
            m_ce <= m_ce_n;
            m_addr <= m_addr_n;
            m_wren <= m_wren_n;
            m_rden <= m_rden_n;
            m_wdata <= m_wdata_n;
            busy <= state_n != IDLE;
            grant_id <= grant_id_n;
        end
    end
endmodule

// File: doc/i2c_request_arbiter.md
Name: i2c_request_arbiter

Overview:
- Round-robin arbiter and transaction sequencer that shares the single APB-side I2C master port (ce/addr/wren/rden/wdata/rdata/ready/error) among N independent requesters.
- Accepts one byte transaction per grant and holds the master's chip-enable for the whole transfer.
- Returns read data or error to the granted requester, enforces a timeout, and inserts a ce-low gap so the master settles in idle before the next start.
- Sits between bus-side requesters (APB bridge, config sequencers) and the I2C master.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- TIMEOUT_CYCLES, 4096, max clk cycles in BUSY before abort.
- GAP_CYCLES, 16, clk cycles m_ce held low after each transaction (minimum 2).

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- req_valid  input  N_REQ  per-requester request; held until req_ack
- req_addr  input  8*N_REQ  packed; slice i = {slave[7:6], mem[5:0]}
- req_wren  input  N_REQ  write request
- req_rden  input  N_REQ  read request
- req_wdata  input  8*N_REQ  packed write data
- req_ack  output  N_REQ  one-cycle pulse: request latched
- rsp_valid  output  N_REQ  one-cycle pulse: transaction finished
- rsp_rdata  output  8  read data, valid with rsp_valid
- rsp_error  output  1  failure, valid with rsp_valid
- rsp_timeout  output  1  failure was a timeout, valid with rsp_valid
- m_ce  output  1  master chip enable
- m_addr  output  8  master address
- m_wren  output  1  master write enable
- m_rden  output  1  master read enable
- m_wdata  output  8  master write data
- m_rdata  input  8  master read data
- m_ready  input  1  master done pulse
- m_error  input  1  master error
- busy  output  1  state != IDLE
- grant_id  output  3  index of the current or last grant

Behaviour:
- All outputs are registered.
- Reset (any state, including mid-transfer):
  - state=IDLE, rr pointer=0, timeout and gap counters=0.
  - All outputs 0; m_ce drops on the next edge.
  - No rsp_valid is issued for the aborted transfer.
- IDLE:
  - Select the first i with req_valid[i]=1, searching from pointer upward with wrap.
  - Legal request (exactly one of wren/rden set):
    - on the edge, latch the request fields to m_addr/m_wren/m_rden/m_wdata (m_wdata=0 for reads);
    - set m_ce=1, req_ack[i]=1 for one cycle, grant_id=i, pointer=(i+1) mod N_REQ;
    - clear the timeout counter; go to BUSY.
  - Illegal request (both or neither set):
    - req_ack[i] and rsp_valid[i] pulse on the same cycle, rsp_error=1, rsp_timeout=0;
    - pointer advances; m_ce stays 0; state stays IDLE.
  - No valid requests: hold; pointer unchanged.
- BUSY:
  - m_ce and the latched fields are held stable; the timeout counter increments each cycle.
  - m_error=1: m_ce<=0; rsp_valid[g]=1, rsp_error=1, rsp_rdata=0; go to GAP.
  - m_error wins over m_ready if both are asserted in the same cycle.
  - m_ready=1 with no m_error: m_ce<=0; rsp_valid[g]=1, rsp_error=0; go to GAP.
    - rsp_rdata=m_rdata for reads, 0 for writes.
  - Counter reaches TIMEOUT_CYCLES-1 with no ready/error: m_ce<=0; rsp_error=1, rsp_timeout=1, rsp_rdata=0; go to GAP.
- GAP:
  - m_ce=0, all m_* fields cleared; count GAP_CYCLES, then go to IDLE.
  - Requests are neither sampled nor acked during BUSY or GAP.
- Latency:
  - req_valid seen high at edge T gives req_ack and m_ce at T+1.
  - m_ready seen at edge R gives rsp_valid at R+1.
  - Earliest next grant is R+1+GAP_CYCLES.
- rsp_valid, req_ack and rsp_* are single-cycle pulses; rsp_error, rsp_timeout and rsp_rdata are 0 whenever no rsp_valid bit is set.
- Requesters that deassert req_valid before ack are simply not granted; there is no latching.
- At most one bit of req_ack and at most one bit of rsp_valid is set in any cycle.

Test Plan:
- Single read: N_REQ=4, req 2 reads addr 0x45, master returns m_rdata=0xA5 with m_ready → req_ack=4'b0100 one cycle after valid; m_ce high until ready; rsp_valid=4'b0100, rsp_rdata=0xA5, rsp_error=0.
- Round-robin: all four requesters valid continuously, pointer=0, each completes with ready → grant order 0,1,2,3,0; m_ce low for exactly 16 cycles between grants.
- Master error: req 1 writes 0x3C to addr 0x81, master asserts m_error and m_ready in the same cycle → rsp_valid=4'b0010, rsp_error=1, rsp_timeout=0, rsp_rdata=0.
- Timeout: TIMEOUT_CYCLES=32, master never responds → m_ce falls exactly 32 cycles after rising; rsp_error=1, rsp_timeout=1; next grant proceeds after the gap.
- Illegal request: req 3 with wren=rden=1 → same-cycle req_ack[3] and rsp_valid[3], rsp_error=1; m_ce never rises; pointer moves to 0.
- Reset mid-BUSY: assert reset 10 cycles into a read → next edge all outputs 0, busy=0, no rsp_valid; after release, pending req 0 is granted first.
